// File: rtl/gf2k_exp_seq_if.sv
// Request/response bundle for the GF(2^DEG) exponentiation engine.
interface gf2k_exp_seq_if #(
   parameter int DEG   = 5,
   parameter int EXP_W = 8
);
   logic [DEG:0]     POLY;
   logic             START;
   logic [DEG-1:0]   BASE;
   logic [EXP_W-1:0] EXP;
   logic             BUSY;
   logic             DONE;
   logic [DEG-1:0]   RESULT;

   modport master (output POLY, START, BASE, EXP, input BUSY, DONE, RESULT);
   modport slave  (input POLY, START, BASE, EXP, output BUSY, DONE, RESULT);
endinterface

// File: rtl/gf2k_exp_seq.sv
// Sequential GF(2^DEG) exponentiation, left-to-right square-and-multiply on one shared multiplier.
// Define GF2K_EXP_SKIP_EN to skip leading exponent zeros (variable latency).

// Combinational GF(2^DEG) multiply: MSB-first shift/add with interleaved reduction.
module gf2k_exp_seq_mul #(
   parameter int DEG = 5
) (
   input  logic [DEG-1:0] a,
   input  logic [DEG-1:0] b,
   input  logic [DEG:0]   poly,
   output logic [DEG-1:0] p
);
   logic [DEG:0][DEG-1:0] part;

   assign part[0] = '0;
   for (genvar i = 0; i < DEG; i++) begin : g_step
      logic red;
      assign red = part[i][DEG-1] & poly[DEG];
      assign part[i+1] = (part[i] << 1) ^ (red ? poly[DEG-1:0] : '0) ^ (b[DEG-1-i] ? a : '0);
   end
   assign p = part[DEG];
endmodule

module gf2k_exp_seq #(
   parameter int DEG   = 5,
   parameter int EXP_W = 8
) (
   input logic          CLK,
   input logic          RST,
   gf2k_exp_seq_if.slave bus
);
   localparam int IDX_W = $clog2(EXP_W) + 1;
   localparam logic [DEG-1:0]   ONE     = DEG'(1);
   localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

   typedef enum logic [1:0] {IDLE, SQR, MUL, FIN} state_t;

   state_t           state;
   logic [DEG-1:0]   acc, base_r, mul_b, prod, result;
   logic [EXP_W-1:0] exp_r, exp_sh;
   logic [DEG:0]     poly_r;
   logic [IDX_W-1:0] idx;
   logic             busy, done, cur_bit;

   assign mul_b   = (state == MUL) ? base_r : acc;
   assign exp_sh  = exp_r >> idx;
   assign cur_bit = exp_sh[0];

   gf2k_exp_seq_mul #(.DEG(DEG)) u_mul (
      .a    (acc),
      .b    (mul_b),
      .poly (poly_r),
      .p    (prod)
   );

`ifdef GF2K_EXP_SKIP_EN
   logic [IDX_W-1:0] msb;
   logic             exp_nz;

   always_comb begin
      msb    = '0;
      exp_nz = |bus.EXP;
      for (int i = 0; i < EXP_W; i++)
         if (bus.EXP[i]) msb = IDX_W'(i);
   end
`endif

   always_ff @(posedge CLK) begin
      if (RST) begin
         state  <= IDLE;
         acc    <= '0;
         base_r <= '0;
         exp_r  <= '0;
         poly_r <= '0;
         idx    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
      end else begin
         case (state)
            IDLE: if (bus.START) begin
               poly_r <= bus.POLY;
               base_r <= bus.BASE;
               exp_r  <= bus.EXP;
`ifdef GF2K_EXP_SKIP_EN
               // The top set bit is consumed as acc=BASE, so no first square is needed.
               if (!exp_nz) begin
                  acc    <= ONE;
                  idx    <= '0;
                  state  <= FIN;
                  done   <= 1'b1;
                  result <= ONE;
               end else if (msb == '0) begin
                  acc    <= bus.BASE;
                  idx    <= '0;
                  state  <= FIN;
                  done   <= 1'b1;
                  result <= bus.BASE;
               end else begin
                  acc   <= bus.BASE;
                  idx   <= msb - IDX_ONE;
                  state <= SQR;
                  busy  <= 1'b1;
               end
`else
               acc   <= ONE;
               idx   <= IDX_W'(EXP_W - 1);
               state <= SQR;
               busy  <= 1'b1;
`endif
            end
            SQR: begin
               acc <= prod;
               if (cur_bit) begin
                  state <= MUL;
               end else if (idx == '0) begin
                  state  <= FIN;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  result <= prod;
               end else begin
                  idx <= idx - IDX_ONE;
               end
            end
            MUL: begin
               acc <= prod;
               if (idx == '0) begin
                  state  <= FIN;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  result <= prod;
               end else begin
                  idx   <= idx - IDX_ONE;
                  state <= SQR;
               end
            end
            default: begin
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.BUSY   = busy;
   assign bus.DONE   = done;
   assign bus.RESULT = result;
endmodule
